// File: rtl/mux_rr_arbiter.sv
// N-channel show-ahead FIFO drain mux with round-robin or fixed-priority selection,
// burst-limited grants and a downstream pause.
module mux_rr_arbiter #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int MODE   = 0,
    parameter int BURST  = 1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        fifo_empty,
    input  logic                     out_pause,
    output logic [NUM_CH-1:0]        pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    output logic [CH_W-1:0]          grant_id
);

    // state      | meaning
    // ST_IDLE    | no grant held; a winner is picked and popped in the same cycle
    // ST_GRANT   | channel cur held for the rest of its burst
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic              state;
    logic [CH_W-1:0]   cur;
    logic [CH_W-1:0]   last_grant;
    logic [7:0]        burst_cnt;

    logic              win_found;
    logic [CH_W-1:0]   win_id;
    logic [CH_W-1:0]   sel_ch;
    logic              sel_ok;
    logic              do_pop;
    logic              burst_end;
    logic              cur_empty;
    logic [DATA_W-1:0] sel_word;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        if (MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (!fifo_empty[i]) begin
                    win_found = 1'b1;
                    win_id    = CH_W'(i);
                end
            end
        end else begin
            // Modulo search keeps non-power-of-two channel counts correct.
            for (int off = 1; off <= NUM_CH; off++) begin
                idx = (int'(last_grant) + off) % NUM_CH;
                if (!win_found && !fifo_empty[idx]) begin
                    win_found = 1'b1;
                    win_id    = CH_W'(idx);
                end
            end
        end
    end

    always_comb begin
        cur_empty = fifo_empty[int'(cur)];
        if (state == ST_GRANT) begin
            sel_ch = cur;
            sel_ok = !cur_empty;
        end else begin
            sel_ch = win_id;
            sel_ok = win_found;
        end
        do_pop    = reset_L && !out_pause && sel_ok;
        burst_end = (burst_cnt == 8'(BURST - 1));
        sel_word  = data_in[int'(sel_ch)*DATA_W +: DATA_W];
        pop       = '0;
        if (do_pop) begin
            pop[int'(sel_ch)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            grant_id   <= '0;
            burst_cnt  <= '0;
            state      <= ST_IDLE;
            cur        <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            valid_out <= do_pop;
            if (do_pop) begin
                data_out <= sel_word;
                grant_id <= sel_ch;
            end
            if (do_pop && burst_end) begin
                state      <= ST_IDLE;
                last_grant <= sel_ch;
                burst_cnt  <= '0;
            end else if (do_pop) begin
                state     <= ST_GRANT;
                cur       <= sel_ch;
                burst_cnt <= burst_cnt + 8'd1;
            end else if (state == ST_GRANT && cur_empty) begin
                // Burst cut short: release the grant, re-arbitrate next cycle.
                state      <= ST_IDLE;
                last_grant <= cur;
                burst_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: three arbiter instances (RR/BURST=1, RR/BURST=3, fixed priority)
// fed by small show-ahead FIFO models.
module tb_mux_rr_arbiter;

    logic        clk;
    logic        reset_L;
    logic [47:0] din   [3];
    logic [3:0]  fe    [3];
    logic        pause [3];
    logic [3:0]  popv  [3];
    logic [11:0] dout  [3];
    logic        vout  [3];
    logic [1:0]  gid   [3];

    logic [11:0] mem [3][4][16];
    int          wr  [3][4];
    int          rd  [3][4];

    logic [1:0]  exp_g [16];
    logic [11:0] exp_d [16];

    int checks;
    int failures;

    mux_rr_arbiter #(.DATA_W(12), .NUM_CH(4), .CH_W(2), .MODE(0), .BURST(1)) u_rr (
        .clk(clk), .reset_L(reset_L), .data_in(din[0]), .fifo_empty(fe[0]),
        .out_pause(pause[0]), .pop(popv[0]), .data_out(dout[0]),
        .valid_out(vout[0]), .grant_id(gid[0]));

    mux_rr_arbiter #(.DATA_W(12), .NUM_CH(4), .CH_W(2), .MODE(0), .BURST(3)) u_burst (
        .clk(clk), .reset_L(reset_L), .data_in(din[1]), .fifo_empty(fe[1]),
        .out_pause(pause[1]), .pop(popv[1]), .data_out(dout[1]),
        .valid_out(vout[1]), .grant_id(gid[1]));

    mux_rr_arbiter #(.DATA_W(12), .NUM_CH(4), .CH_W(2), .MODE(1), .BURST(1)) u_prio (
        .clk(clk), .reset_L(reset_L), .data_in(din[2]), .fifo_empty(fe[2]),
        .out_pause(pause[2]), .pop(popv[2]), .data_out(dout[2]),
        .valid_out(vout[2]), .grant_id(gid[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            din[k] = '0;
            fe[k]  = '0;
            for (int c = 0; c < 4; c++) begin
                din[k][c*12 +: 12] = mem[k][c][rd[k][c] % 16];
                fe[k][c]           = (wr[k][c] == rd[k][c]);
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (popv[k][c]) rd[k][c] <= rd[k][c] + 1;
            end
        end
    end

    task automatic load(input int k, input int c, input logic [11:0] val);
        mem[k][c][wr[k][c] % 16] = val;
        wr[k][c] = wr[k][c] + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input int i, input logic [1:0] g, input logic [11:0] d);
        exp_g[i] = g;
        exp_d[i] = d;
    endtask

    // Gathers n valid words from instance k within budget cycles and checks order.
    task automatic collect(input int k, input int n, input int budget, input string tag);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            #1;
            if (vout[k]) begin
                chk({tag, "_gid"}, 32'(gid[k]), 32'(exp_g[got]));
                chk({tag, "_data"}, 32'(dout[k]), 32'(exp_d[got]));
                got++;
            end
        end
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            pause[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                wr[k][c] = 0;
                rd[k][c] = 0;
                for (int j = 0; j < 16; j++) mem[k][c][j] = '0;
            end
        end
        reset_L = 1'b0;

        // Single channel after reset; pop must stay low while in reset.
        load(0, 1, 12'h402);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_data", 32'(dout[0]), 0);
        chk("rst_valid", 32'(vout[0]), 0);
        chk("rst_gid", 32'(gid[0]), 0);
        chk("rst_pop", 32'(popv[0]), 0);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        chk("single_pop", 32'(popv[0]), 32'h2);
        @(negedge clk);
        #1;
        chk("single_data", 32'(dout[0]), 32'h402);
        chk("single_valid", 32'(vout[0]), 1);
        chk("single_gid", 32'(gid[0]), 1);
        chk("single_pop_after", 32'(popv[0]), 0);

        // Round-robin fairness, all four channels loaded, restart from channel 0.
        @(negedge clk);
        reset_L = 1'b0;
        for (int c = 0; c < 4; c++) begin
            load(0, c, 12'(c * 12'h401 + 1));
            load(0, c, 12'(c * 12'h401 + 1 + 12'h010));
        end
        for (int i = 0; i < 8; i++) begin
            set_exp(i, 2'(i % 4), 12'((i % 4) * 12'h401 + 1 + (i / 4) * 12'h010));
        end
        @(negedge clk);
        reset_L = 1'b1;
        collect(0, 8, 8, "rr");
        @(negedge clk);
        #1;
        chk("rr_drained_valid", 32'(vout[0]), 0);

        // BURST=3: two channels of five words each.
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            load(1, 0, 12'(12'h100 + j));
            load(1, 2, 12'(12'h300 + j));
        end
        set_exp(0, 0, 12'h100); set_exp(1, 0, 12'h101); set_exp(2, 0, 12'h102);
        set_exp(3, 2, 12'h300); set_exp(4, 2, 12'h301); set_exp(5, 2, 12'h302);
        set_exp(6, 0, 12'h103); set_exp(7, 0, 12'h104);
        set_exp(8, 2, 12'h303); set_exp(9, 2, 12'h304);
        collect(1, 10, 14, "burst");

        // Fixed priority: channel 1 fully drained before channel 3.
        @(negedge clk);
        load(2, 3, 12'h3A0);
        load(2, 3, 12'h3A1);
        load(2, 1, 12'h1B0);
        load(2, 1, 12'h1B1);
        load(2, 1, 12'h1B2);
        set_exp(0, 1, 12'h1B0); set_exp(1, 1, 12'h1B1); set_exp(2, 1, 12'h1B2);
        set_exp(3, 3, 12'h3A0); set_exp(4, 3, 12'h3A1);
        collect(2, 5, 5, "prio");

        // Pause mid-burst on the BURST=3 instance; ch2 arrives during the pause.
        @(negedge clk);
        for (int j = 0; j < 5; j++) load(1, 0, 12'(12'h0A0 + j));
        @(negedge clk);
        #1;
        chk("pause_w0", 32'(dout[1]), 32'h0A0);
        @(negedge clk);
        #1;
        chk("pause_w1", 32'(dout[1]), 32'h0A1);
        pause[1] = 1'b1;
        #1;
        chk("pause_pop_now", 32'(popv[1]), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) load(1, 2, 12'h0C0);
            #1;
            chk("pause_valid", 32'(vout[1]), 0);
            chk("pause_hold", 32'(dout[1]), 32'h0A1);
            chk("pause_pop", 32'(popv[1]), 0);
        end
        pause[1] = 1'b0;
        #1;
        chk("resume_pop", 32'(popv[1]), 32'h1);
        set_exp(0, 0, 12'h0A2); set_exp(1, 2, 12'h0C0);
        set_exp(2, 0, 12'h0A3); set_exp(3, 0, 12'h0A4);
        collect(1, 4, 12, "resume");

        // Asynchronous reset mid-burst, then restart at channel 0.
        @(negedge clk);
        for (int j = 0; j < 4; j++) load(1, 0, 12'(12'h0E0 + j));
        @(negedge clk);
        #1;
        chk("arst_pre_w0", 32'(dout[1]), 32'h0E0);
        @(negedge clk);
        #1;
        chk("arst_pre_w1", 32'(dout[1]), 32'h0E1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_data", 32'(dout[1]), 0);
        chk("arst_valid", 32'(vout[1]), 0);
        chk("arst_gid", 32'(gid[1]), 0);
        chk("arst_pop", 32'(popv[1]), 0);
        load(1, 3, 12'h3E0);
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        chk("arst_first_pop", 32'(popv[1]), 32'h1);
        set_exp(0, 0, 12'h0E2); set_exp(1, 0, 12'h0E3); set_exp(2, 3, 12'h3E0);
        collect(1, 3, 6, "arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
